// File: rtl/axi_ddr_responder.sv
// Single-beat AXI4 responder standing in for the DDR2 controller slave port.
// Models calibration delay, programmable read latency and byte-strobed writes.
module axi_ddr_responder #(
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned RD_LAT       = 8,
  parameter int unsigned CALIB_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         calib_done,
  input  logic [31:0]  S_AXI_awaddr,
  input  logic [7:0]   S_AXI_awlen,
  input  logic         S_AXI_awid,
  input  logic         S_AXI_awvalid,
  output logic         S_AXI_awready,
  input  logic [127:0] S_AXI_wdata,
  input  logic [15:0]  S_AXI_wstrb,
  input  logic         S_AXI_wlast,
  input  logic         S_AXI_wvalid,
  output logic         S_AXI_wready,
  output logic         S_AXI_bvalid,
  input  logic         S_AXI_bready,
  output logic [1:0]   S_AXI_bresp,
  output logic         S_AXI_bid,
  input  logic [31:0]  S_AXI_araddr,
  input  logic [7:0]   S_AXI_arlen,
  input  logic         S_AXI_arid,
  input  logic         S_AXI_arvalid,
  output logic         S_AXI_arready,
  output logic [127:0] S_AXI_rdata,
  output logic [1:0]   S_AXI_rresp,
  output logic         S_AXI_rid,
  output logic         S_AXI_rlast,
  output logic         S_AXI_rvalid,
  input  logic         S_AXI_rready
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned LatW = $clog2(RD_LAT + 1);
  localparam int unsigned CalW = $clog2(CALIB_CYCLES + 1);

  logic [127:0] mem [DEPTH];

  // Calibration counter
  logic [CalW-1:0] cal_cnt_q;
  logic            calib_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cal_cnt_q <= '0;
      calib_q   <= 1'b0;
    end else if (!calib_q) begin
      if (cal_cnt_q == CalW'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
      cal_cnt_q <= cal_cnt_q + 1'b1;
    end
  end

  assign calib_done = calib_q;

  // Write engine: independent AW and W holding registers
  logic            aw_full_q, aw_id_q, aw_err_q;
  logic [IdxW-1:0] aw_idx_q;
  logic            w_full_q;
  logic [127:0]    w_data_q;
  logic [15:0]     w_strb_q;
  logic            bvalid_q, bid_q;
  logic [1:0]      bresp_q;
  logic            aw_hs, w_hs, commit;

  assign S_AXI_awready = calib_q & ~aw_full_q & ~bvalid_q;
  assign S_AXI_wready  = calib_q & ~w_full_q & ~bvalid_q;
  assign aw_hs         = S_AXI_awvalid & S_AXI_awready;
  assign w_hs          = S_AXI_wvalid & S_AXI_wready;
  assign commit        = aw_full_q & w_full_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      aw_id_q   <= 1'b0;
      aw_err_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= S_AXI_awaddr[4 +: IdxW];
        aw_id_q   <= S_AXI_awid;
        aw_err_q  <= (S_AXI_awlen != 8'd0);
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= S_AXI_wdata;
        w_strb_q <= S_AXI_wstrb;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= aw_err_q ? 2'b10 : 2'b00;
        bid_q     <= aw_id_q;
      end else if (bvalid_q && S_AXI_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_bvalid = bvalid_q;
  assign S_AXI_bresp  = bresp_q;
  assign S_AXI_bid    = bid_q;

  // Array contents survive reset; a length error suppresses the write entirely
  always_ff @(posedge clk) begin
    if (rst_n && commit && !aw_err_q) begin
      for (int b = 0; b < 16; b++) begin
        if (w_strb_q[b]) mem[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  // Read engine
  typedef enum logic [1:0] {StIdle, StWait, StResp} rd_state_e;

  rd_state_e       state_q, state_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic [IdxW-1:0] ar_idx_q;
  logic            ar_id_q, ar_err_q;
  logic            ar_load, r_sample;
  logic            rvalid_q, rid_q;
  logic [127:0]    rdata_q;
  logic [1:0]      rresp_q;

  assign S_AXI_arready = calib_q & (state_q == StIdle);

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    ar_load  = 1'b0;
    r_sample = 1'b0;
    case (state_q)
      StIdle: begin
        if (S_AXI_arvalid && S_AXI_arready) begin
          state_d = StWait;
          lat_d   = LatW'(RD_LAT);
          ar_load = 1'b1;
        end
      end
      StWait: begin
        if (lat_q == LatW'(1)) begin
          state_d  = StResp;
          lat_d    = '0;
          r_sample = 1'b1;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StResp: begin
        if (S_AXI_rready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sampling mem here sees the pre-edge contents, so a same-edge commit is not visible
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lat_q    <= '0;
      ar_idx_q <= '0;
      ar_id_q  <= 1'b0;
      ar_err_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      rid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (ar_load) begin
        ar_idx_q <= S_AXI_araddr[4 +: IdxW];
        ar_id_q  <= S_AXI_arid;
        ar_err_q <= (S_AXI_arlen != 8'd0);
      end
      if (r_sample) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_err_q ? '0 : mem[ar_idx_q];
        rresp_q  <= ar_err_q ? 2'b10 : 2'b00;
        rid_q    <= ar_id_q;
      end else if (rvalid_q && S_AXI_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_rvalid = rvalid_q;
  assign S_AXI_rdata  = rdata_q;
  assign S_AXI_rresp  = rresp_q;
  assign S_AXI_rid    = rid_q;
  assign S_AXI_rlast  = rvalid_q;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_awaddr[3:0], S_AXI_awaddr[31:4+IdxW], S_AXI_araddr[3:0],
                         S_AXI_araddr[31:4+IdxW], S_AXI_wlast};

endmodule

// File: tb/tb_axi_ddr_responder.sv
// Scoreboard bench for axi_ddr_responder: calibration, strobes, ordering,
// backpressure, wrap, length errors, read/commit collision and mid-read reset.
module tb_axi_ddr_responder;

  localparam int unsigned DEPTH        = 256;
  localparam int unsigned RD_LAT       = 8;
  localparam int unsigned CALIB_CYCLES = 64;
  localparam int unsigned IdxW         = $clog2(DEPTH);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         calib_done;
  logic [31:0]  S_AXI_awaddr = '0;
  logic [7:0]   S_AXI_awlen = '0;
  logic         S_AXI_awid = 1'b0;
  logic         S_AXI_awvalid = 1'b0;
  logic         S_AXI_awready;
  logic [127:0] S_AXI_wdata = '0;
  logic [15:0]  S_AXI_wstrb = '0;
  logic         S_AXI_wlast = 1'b1;
  logic         S_AXI_wvalid = 1'b0;
  logic         S_AXI_wready;
  logic         S_AXI_bvalid;
  logic         S_AXI_bready = 1'b0;
  logic [1:0]   S_AXI_bresp;
  logic         S_AXI_bid;
  logic [31:0]  S_AXI_araddr = '0;
  logic [7:0]   S_AXI_arlen = '0;
  logic         S_AXI_arid = 1'b0;
  logic         S_AXI_arvalid = 1'b0;
  logic         S_AXI_arready;
  logic [127:0] S_AXI_rdata;
  logic [1:0]   S_AXI_rresp;
  logic         S_AXI_rid;
  logic         S_AXI_rlast;
  logic         S_AXI_rvalid;
  logic         S_AXI_rready = 1'b0;

  always #5 clk = ~clk;

  axi_ddr_responder #(
    .DEPTH       (DEPTH),
    .RD_LAT      (RD_LAT),
    .CALIB_CYCLES(CALIB_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .calib_done   (calib_done),
    .S_AXI_awaddr (S_AXI_awaddr),
    .S_AXI_awlen  (S_AXI_awlen),
    .S_AXI_awid   (S_AXI_awid),
    .S_AXI_awvalid(S_AXI_awvalid),
    .S_AXI_awready(S_AXI_awready),
    .S_AXI_wdata  (S_AXI_wdata),
    .S_AXI_wstrb  (S_AXI_wstrb),
    .S_AXI_wlast  (S_AXI_wlast),
    .S_AXI_wvalid (S_AXI_wvalid),
    .S_AXI_wready (S_AXI_wready),
    .S_AXI_bvalid (S_AXI_bvalid),
    .S_AXI_bready (S_AXI_bready),
    .S_AXI_bresp  (S_AXI_bresp),
    .S_AXI_bid    (S_AXI_bid),
    .S_AXI_araddr (S_AXI_araddr),
    .S_AXI_arlen  (S_AXI_arlen),
    .S_AXI_arid   (S_AXI_arid),
    .S_AXI_arvalid(S_AXI_arvalid),
    .S_AXI_arready(S_AXI_arready),
    .S_AXI_rdata  (S_AXI_rdata),
    .S_AXI_rresp  (S_AXI_rresp),
    .S_AXI_rid    (S_AXI_rid),
    .S_AXI_rlast  (S_AXI_rlast),
    .S_AXI_rvalid (S_AXI_rvalid),
    .S_AXI_rready (S_AXI_rready)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   resp;
    logic         id;
  } r_exp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       id;
  } b_exp_t;

  r_exp_t       rq[$];
  b_exp_t       bq[$];
  logic [127:0] model [DEPTH];
  int           checks = 0;
  int           failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [IdxW-1:0] idx_of(input logic [31:0] a);
    return a[4 +: IdxW];
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [127:0] data,
                             input logic [15:0] strb);
    for (int b = 0; b < 16; b++) begin
      if (strb[b]) model[idx_of(addr)][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  function automatic logic any_out();
    return |{calib_done, S_AXI_awready, S_AXI_wready, S_AXI_arready, S_AXI_bvalid,
             S_AXI_rvalid, S_AXI_bresp, S_AXI_rresp, S_AXI_bid, S_AXI_rid, S_AXI_rlast,
             S_AXI_rdata};
  endfunction

  // Entered at the negedge after the commit edge
  task automatic b_collect(input int stall);
    b_exp_t e;
    check("b_valid", 128'(S_AXI_bvalid), 128'd1);
    if (bq.size() == 0) begin
      check("b_sb_empty", 128'(bq.size()), 128'd1);
      e = '0;
    end else begin
      e = bq.pop_front();
      check("bresp", 128'(S_AXI_bresp), 128'(e.resp));
      check("bid", 128'(S_AXI_bid), 128'(e.id));
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("b_hold_valid", 128'(S_AXI_bvalid), 128'd1);
      check("b_hold_resp", 128'({S_AXI_bresp, S_AXI_bid}), 128'({e.resp, e.id}));
      check("awready_stall", 128'(S_AXI_awready), 128'd0);
    end
    S_AXI_bready = 1'b1;
    @(negedge clk);
    S_AXI_bready = 1'b0;
    check("b_drop", 128'(S_AXI_bvalid), 128'd0);
    check("awready_back", 128'(S_AXI_awready), 128'd1);
  endtask

  // W is presented w_lead cycles before AW (0 = same cycle)
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic id,
                           input logic [127:0] data, input logic [15:0] strb,
                           input int w_lead, input int b_stall);
    int     n;
    bit     aw_done, w_done, aw_f, w_f;
    b_exp_t e;
    e.resp = (len != 8'd0) ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);
    if (len == 8'd0) model_write(addr, data, strb);
    aw_done = 1'b0;
    w_done  = 1'b0;
    n       = 0;
    @(negedge clk);
    S_AXI_wdata   = data;
    S_AXI_wstrb   = strb;
    S_AXI_wvalid  = 1'b1;
    S_AXI_awaddr  = addr;
    S_AXI_awlen   = len;
    S_AXI_awid    = id;
    S_AXI_awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && n < 200) begin
      aw_f = S_AXI_awvalid && S_AXI_awready;
      w_f  = S_AXI_wvalid && S_AXI_wready;
      @(negedge clk);
      n++;
      if (aw_f) begin aw_done = 1'b1; S_AXI_awvalid = 1'b0; end
      if (w_f) begin w_done = 1'b1; S_AXI_wvalid = 1'b0; end
      if (n == w_lead && !aw_done) S_AXI_awvalid = 1'b1;
    end
    check("wr_handshake", 128'({aw_done, w_done}), 128'd3);
    if (!(aw_done && w_done)) return;
    check("b_early", 128'(S_AXI_bvalid), 128'd0);
    @(negedge clk);
    b_collect(b_stall);
  endtask

  // Returns at the negedge after the AR handshake edge
  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic id);
    r_exp_t e;
    int     n;
    e.data = (len != 8'd0) ? 128'd0 : model[idx_of(addr)];
    e.resp = (len != 8'd0) ? 2'b10 : 2'b00;
    e.id   = id;
    rq.push_back(e);
    @(negedge clk);
    S_AXI_araddr  = addr;
    S_AXI_arlen   = len;
    S_AXI_arid    = id;
    S_AXI_arvalid = 1'b1;
    n = 0;
    while (!S_AXI_arready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ar_ready", 128'(S_AXI_arready), 128'd1);
    @(negedge clk);
    S_AXI_arvalid = 1'b0;
    check("ar_busy", 128'(S_AXI_arready), 128'd0);
  endtask

  // k0 = edges already elapsed since the AR handshake
  task automatic r_collect(input int k0, input int stall);
    int     k;
    r_exp_t e;
    k = k0;
    while (!S_AXI_rvalid && k < int'(RD_LAT) + 20) begin
      @(negedge clk);
      k++;
    end
    check("r_latency", 128'(k), 128'(RD_LAT));
    if (rq.size() == 0) begin
      check("r_sb_empty", 128'(rq.size()), 128'd1);
      e = '0;
    end else begin
      e = rq.pop_front();
      check("rdata", S_AXI_rdata, e.data);
      check("rresp", 128'(S_AXI_rresp), 128'(e.resp));
      check("rid", 128'(S_AXI_rid), 128'(e.id));
      check("rlast", 128'(S_AXI_rlast), 128'd1);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("r_hold", 128'({S_AXI_rvalid, S_AXI_rresp, S_AXI_rid}),
            128'({1'b1, e.resp, e.id}));
      check("r_hold_data", S_AXI_rdata, e.data);
    end
    S_AXI_rready = 1'b1;
    @(negedge clk);
    S_AXI_rready = 1'b0;
    check("r_drop", 128'(S_AXI_rvalid), 128'd0);
    check("arready_back", 128'(S_AXI_arready), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic bad;
    logic [127:0] d_full, d_strb, d_wrap, d_old, d_new;
    d_full = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    d_strb = 128'h1111_2222_3333_4444_5555_6666_AABB_CCDD;
    d_wrap = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;
    d_old  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    d_new  = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_outs", 128'(any_out()), 128'd0);

    // Calibration with AW held valid throughout
    S_AXI_awaddr  = 32'h40;
    S_AXI_awvalid = 1'b1;
    rst_n = 1'b1;
    for (int k = 1; k <= int'(CALIB_CYCLES); k++) begin
      @(negedge clk);
      if (k == int'(CALIB_CYCLES) - 1) begin
        check("calib_early", 128'(calib_done), 128'd0);
        check("ready_early", 128'({S_AXI_awready, S_AXI_wready, S_AXI_arready}), 128'd0);
      end
      if (k == int'(CALIB_CYCLES)) begin
        check("calib_done", 128'(calib_done), 128'd1);
        check("awready_calib", 128'(S_AXI_awready), 128'd1);
        S_AXI_awvalid = 1'b0;
      end
    end

    // Full-word write then read
    axi_write(32'h40, 8'd0, 1'b1, d_full, 16'hFFFF, 0, 0);
    ar_issue(32'h40, 8'd0, 1'b1);
    r_collect(0, 2);

    // Strobed write with W leading AW by three cycles
    axi_write(32'h40, 8'd0, 1'b0, d_strb, 16'h000F, 3, 0);
    ar_issue(32'h40, 8'd0, 1'b0);
    r_collect(0, 0);

    // Response backpressure and address wrap
    axi_write(DEPTH * 16 + 32'h10, 8'd0, 1'b1, d_wrap, 16'hFFFF, 0, 5);
    ar_issue(32'h10, 8'd0, 1'b1);
    r_collect(0, 0);

    // Length errors
    ar_issue(32'h40, 8'd3, 1'b1);
    r_collect(0, 0);
    axi_write(32'h40, 8'd1, 1'b1, d_new, 16'hFFFF, 0, 0);
    ar_issue(32'h40, 8'd0, 1'b0);
    r_collect(0, 0);

    // Commit to the same word on the edge rvalid rises returns old data
    axi_write(32'h80, 8'd0, 1'b0, d_old, 16'hFFFF, 0, 0);
    ar_issue(32'h80, 8'd0, 1'b1);
    repeat (RD_LAT - 2) @(negedge clk);
    bq.push_back('{resp: 2'b00, id: 1'b1});
    S_AXI_awaddr  = 32'h80;
    S_AXI_awlen   = 8'd0;
    S_AXI_awid    = 1'b1;
    S_AXI_wdata   = d_new;
    S_AXI_wstrb   = 16'hFFFF;
    S_AXI_awvalid = 1'b1;
    S_AXI_wvalid  = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0;
    S_AXI_wvalid  = 1'b0;
    check("coll_captured", 128'({S_AXI_awready, S_AXI_wready}), 128'd0);
    model_write(32'h80, d_new, 16'hFFFF);
    r_collect(RD_LAT - 1, 0);
    b_collect(0);
    ar_issue(32'h80, 8'd0, 1'b0);
    r_collect(0, 0);

    // Reset during the read wait drops the transaction
    ar_issue(32'h10, 8'd0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rq.delete();
    bad = 1'b0;
    for (int k = 1; k < int'(CALIB_CYCLES); k++) begin
      @(negedge clk);
      bad |= any_out();
    end
    check("reset_quiet", 128'(bad), 128'd0);
    @(negedge clk);
    check("recalib", 128'(calib_done), 128'd1);
    bad = 1'b0;
    repeat (RD_LAT + 2) begin
      @(negedge clk);
      bad |= S_AXI_rvalid | S_AXI_bvalid;
    end
    check("no_stale_resp", 128'(bad), 128'd0);
    ar_issue(32'h10, 8'd0, 1'b0);
    r_collect(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
